// File: rtl/lab6_pkg.sv
// Shared definitions for the Lab6 instruction issuer: opcode/ALU_op encodings,
// instruction field positions, issuer FSM states and the legality check.
package lab6_pkg;

  // Opcode encodings
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // ALU_op encodings under OPC_MOV
  localparam logic [1:0] ALU_MOV_IMM = 2'b10;
  localparam logic [1:0] ALU_MOV_REG = 2'b00;

  // ALU_op encodings under OPC_ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Instruction field bit positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int AOP_HI = 12;
  localparam int AOP_LO = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Issuer FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACK   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DRAIN = 3'd4
  } issuer_state_e;

  // True for the six encodings the controller implements
  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] aop);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_MOV: ok = (aop == ALU_MOV_IMM) || (aop == ALU_MOV_REG);
      OPC_ALU: ok = 1'b1;  // ADD, CMP, AND, MVN all implemented
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when the instruction updates status flags
  function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] aop);
    return (opc == OPC_ALU) && (aop == ALU_CMP);
  endfunction

endpackage

// File: rtl/lab6_instr_decode.sv
// Combinational instruction decode: field split, imm8 sign extension and
// legality. Kept standalone so a fetch unit can reuse it.
module lab6_instr_decode
  import lab6_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [1:0]  alu_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  r_n,
  output logic [2:0]  r_d,
  output logic [2:0]  r_m,
  output logic [15:0] sximm8,
  output logic        legal
);

  logic [7:0] imm8;

  // Split the instruction into its fields and classify it
  always_comb begin
    opcode   = instr[OPC_HI:OPC_LO];
    alu_op   = instr[AOP_HI:AOP_LO];
    r_n      = instr[RN_HI:RN_LO];
    r_d      = instr[RD_HI:RD_LO];
    shift_op = instr[SH_HI:SH_LO];
    r_m      = instr[RM_HI:RM_LO];
    imm8     = instr[IMM_HI:IMM_LO];
    sximm8   = {{8{imm8[7]}}, imm8};
    legal    = is_legal(opcode, alu_op);
  end

endmodule

// File: rtl/lab6_issuer.sv
// Lab6 instruction issuer: accepts instructions, pulses start to the
// controller, follows its waiting signal through acknowledge and completion,
// then retires the instruction and counts retired/illegal instructions.
// Optional macro LAB6_ISSUER_B2B_EN: accept the next instruction in DRAIN.
module lab6_issuer
  import lab6_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  input  logic             waiting,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  output logic             start,
  output logic [2:0]       opcode,
  output logic [1:0]       ALU_op,
  output logic [1:0]       shift_op,
  output logic [2:0]       r_n,
  output logic [2:0]       r_d,
  output logic [2:0]       r_m,
  output logic [15:0]      sximm8,
  output logic             busy,
  output logic             retire,
  output logic             illegal,
  output logic             ack_err,
  output logic [2:0]       flags_q,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  issuer_state_e    state_q, state_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;

  logic [2:0]       opcode_q, opcode_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [1:0]       shift_op_q, shift_op_d;
  logic [2:0]       r_n_q, r_n_d;
  logic [2:0]       r_d_q, r_d_d;
  logic [2:0]       r_m_q, r_m_d;
  logic [15:0]      sximm8_q, sximm8_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       flags_cap_q, flags_cap_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic [2:0]       dec_opcode;
  logic [1:0]       dec_alu_op;
  logic [1:0]       dec_shift_op;
  logic [2:0]       dec_r_n;
  logic [2:0]       dec_r_d;
  logic [2:0]       dec_r_m;
  logic [15:0]      dec_sximm8;
  logic             dec_legal;
  logic             accept;
  logic             ack_timeout;

  lab6_instr_decode u_decode (
    .instr    (instr),
    .opcode   (dec_opcode),
    .alu_op   (dec_alu_op),
    .shift_op (dec_shift_op),
    .r_n      (dec_r_n),
    .r_d      (dec_r_d),
    .r_m      (dec_r_m),
    .sximm8   (dec_sximm8),
    .legal    (dec_legal)
  );

  assign accept      = instr_valid && instr_ready;
  assign ack_timeout = (state_q == ST_ACK) && waiting && (ack_cnt_q == ACK_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept && dec_legal) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_ACK;
      ST_ACK: begin
        if (!waiting)         state_d = ST_EXEC;
        else if (ack_timeout) state_d = ST_IDLE;
      end
      ST_EXEC:  if (waiting) state_d = ST_DRAIN;
      ST_DRAIN: begin
        state_d = ST_IDLE;
`ifdef LAB6_ISSUER_B2B_EN
        if (accept && dec_legal) state_d = ST_ISSUE;
`endif
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; start only ever comes from ISSUE so DRAIN cannot re-issue
  always_comb begin
    start       = (state_q == ST_ISSUE);
    busy        = (state_q != ST_IDLE);
    retire      = (state_q == ST_DRAIN);
    ack_err     = ack_timeout;
    instr_ready = 1'b0;
    if (state_q == ST_IDLE) instr_ready = waiting;
`ifdef LAB6_ISSUER_B2B_EN
    if (state_q == ST_DRAIN) instr_ready = waiting;
`endif
  end

  // Next values for ack counter, latched fields, counters and captured flags
  always_comb begin
    ack_cnt_d     = ack_cnt_q;
    opcode_d      = opcode_q;
    alu_op_d      = alu_op_q;
    shift_op_d    = shift_op_q;
    r_n_d         = r_n_q;
    r_d_d         = r_d_q;
    r_m_d         = r_m_q;
    sximm8_d      = sximm8_q;
    flags_cap_d   = flags_cap_q;
    retired_cnt_d = retired_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    illegal_d     = accept && !dec_legal;

    if (state_q == ST_ISSUE) ack_cnt_d = '0;
    else if (state_q == ST_ACK && waiting) ack_cnt_d = ack_cnt_q + ACK_W'(1);

    if (accept) begin
      opcode_d   = dec_opcode;
      alu_op_d   = dec_alu_op;
      shift_op_d = dec_shift_op;
      r_n_d      = dec_r_n;
      r_d_d      = dec_r_d;
      r_m_d      = dec_r_m;
      sximm8_d   = dec_sximm8;
    end

    if (illegal_d) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);

    // Retire and flag capture use the fields of the instruction in DRAIN,
    // which are still in the _q registers even if a new one is being accepted
    if (state_q == ST_DRAIN) begin
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
      if (is_cmp(opcode_q, alu_op_q)) flags_cap_d = {Z, N, V};
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cnt_q     <= '0;
      opcode_q      <= '0;
      alu_op_q      <= '0;
      shift_op_q    <= '0;
      r_n_q         <= '0;
      r_d_q         <= '0;
      r_m_q         <= '0;
      sximm8_q      <= '0;
      illegal_q     <= 1'b0;
      flags_cap_q   <= '0;
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      ack_cnt_q     <= ack_cnt_d;
      opcode_q      <= opcode_d;
      alu_op_q      <= alu_op_d;
      shift_op_q    <= shift_op_d;
      r_n_q         <= r_n_d;
      r_d_q         <= r_d_d;
      r_m_q         <= r_m_d;
      sximm8_q      <= sximm8_d;
      illegal_q     <= illegal_d;
      flags_cap_q   <= flags_cap_d;
      retired_cnt_q <= retired_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign opcode      = opcode_q;
  assign ALU_op      = alu_op_q;
  assign shift_op    = shift_op_q;
  assign r_n         = r_n_q;
  assign r_d         = r_d_q;
  assign r_m         = r_m_q;
  assign sximm8      = sximm8_q;
  assign illegal     = illegal_q;
  assign flags_q     = flags_cap_q;
  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule
